// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals shared by the arbiter
// and its environment. The arbiter uses the slave view; requesters and memory use master.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;

  logic        ls_req;
  logic        ls_we;
  logic [2:0]  ls_funct3;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_ack;
  logic [31:0] ls_rdata;
  logic        ls_err;

  logic [31:0] mem_addr;
  logic [31:0] mem_value;
  logic [2:0]  mem_funct3;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_data;

  logic        busy;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_funct3, ls_addr, ls_wdata, mem_data,
    output if_ack, if_rdata, ls_ack, ls_rdata, ls_err,
           mem_addr, mem_value, mem_funct3, mem_read, mem_write, busy
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_funct3, ls_addr, ls_wdata, mem_data,
    input  if_ack, if_rdata, ls_ack, ls_rdata, ls_err,
           mem_addr, mem_value, mem_funct3, mem_read, mem_write, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between instruction fetch and load/store for one memory port.
// Each grant runs IDLE -> ISSUE -> RESP; every output is registered.
module mem_arbiter #(
  parameter int MEMSIZE = 64
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [31:0] ADDR_LIMIT = 32'(MEMSIZE);

  state_t      state_q, state_d;
  logic        last_ls_q, last_ls_d;
  logic        owner_ls_q, owner_ls_d;
  logic        rd_q, rd_d;
  logic        err_q, err_d;

  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_value_q, mem_value_d;
  logic [2:0]  mem_funct3_q, mem_funct3_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic        if_ack_q, if_ack_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        ls_ack_q, ls_ack_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;
  logic        ls_err_q, ls_err_d;
  logic        busy_q, busy_d;

  logic if_in_range;
  logic ls_in_range;
  logic ls_size_ok;
  logic ls_legal;

  // Loads reject funct3 3, 6 and 7; stores accept only byte, half and word.
  assign if_in_range = bus.if_addr < ADDR_LIMIT;
  assign ls_in_range = bus.ls_addr < ADDR_LIMIT;
  assign ls_size_ok  = bus.ls_we ? (bus.ls_funct3 <= 3'd2)
                                 : !((bus.ls_funct3 == 3'd3) || (bus.ls_funct3[2:1] == 2'b11));
  assign ls_legal    = ls_in_range && ls_size_ok;

  always_comb begin
    state_d      = state_q;
    last_ls_d    = last_ls_q;
    owner_ls_d   = owner_ls_q;
    rd_d         = rd_q;
    err_d        = err_q;
    mem_addr_d   = '0;
    mem_value_d  = '0;
    mem_funct3_d = '0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    if_ack_d     = 1'b0;
    if_rdata_d   = '0;
    ls_ack_d     = 1'b0;
    ls_rdata_d   = '0;
    ls_err_d     = 1'b0;
    busy_d       = 1'b0;

    case (state_q)
      IDLE: begin
        // LSU wins when alone, or on a tie when fetch was granted last.
        if (bus.ls_req && (!bus.if_req || !last_ls_q)) begin
          state_d      = ISSUE;
          busy_d       = 1'b1;
          last_ls_d    = 1'b1;
          owner_ls_d   = 1'b1;
          rd_d         = ls_legal && !bus.ls_we;
          err_d        = !ls_legal;
          mem_addr_d   = bus.ls_addr;
          mem_value_d  = bus.ls_wdata;
          mem_funct3_d = bus.ls_funct3;
          mem_read_d   = ls_legal && !bus.ls_we;
          mem_write_d  = ls_legal && bus.ls_we;
        end else if (bus.if_req) begin
          state_d      = ISSUE;
          busy_d       = 1'b1;
          last_ls_d    = 1'b0;
          owner_ls_d   = 1'b0;
          rd_d         = if_in_range;
          err_d        = 1'b0;
          mem_addr_d   = bus.if_addr;
          mem_funct3_d = 3'd2;
          mem_read_d   = if_in_range;
        end
      end
      ISSUE: begin
        state_d = RESP;
        busy_d  = 1'b1;
      end
      RESP: begin
        // Memory data for the ISSUE-cycle strobe is valid during this cycle.
        state_d = IDLE;
        if (owner_ls_q) begin
          ls_ack_d   = 1'b1;
          ls_err_d   = err_q;
          ls_rdata_d = rd_q ? bus.mem_data : '0;
        end else begin
          if_ack_d   = 1'b1;
          if_rdata_d = rd_q ? bus.mem_data : '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_ls_q    <= 1'b0;
      owner_ls_q   <= 1'b0;
      rd_q         <= 1'b0;
      err_q        <= 1'b0;
      mem_addr_q   <= '0;
      mem_value_q  <= '0;
      mem_funct3_q <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      if_ack_q     <= 1'b0;
      if_rdata_q   <= '0;
      ls_ack_q     <= 1'b0;
      ls_rdata_q   <= '0;
      ls_err_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_ls_q    <= last_ls_d;
      owner_ls_q   <= owner_ls_d;
      rd_q         <= rd_d;
      err_q        <= err_d;
      mem_addr_q   <= mem_addr_d;
      mem_value_q  <= mem_value_d;
      mem_funct3_q <= mem_funct3_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      if_ack_q     <= if_ack_d;
      if_rdata_q   <= if_rdata_d;
      ls_ack_q     <= ls_ack_d;
      ls_rdata_q   <= ls_rdata_d;
      ls_err_q     <= ls_err_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_value  = mem_value_q;
  assign bus.mem_funct3 = mem_funct3_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.if_ack     = if_ack_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.ls_ack     = ls_ack_q;
  assign bus.ls_rdata   = ls_rdata_q;
  assign bus.ls_err     = ls_err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester tasks push expected responses,
// a negedge monitor pops and compares them against every acknowledge.
module tb_mem_arbiter;
  localparam int MEMSIZE = 64;

  typedef struct packed {
    logic        strobe;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] val;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk;
  logic rst;
  mem_arbiter_if bus();

  mem_arbiter #(.MEMSIZE(MEMSIZE)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;
  logic [31:0] tb_mem  [MEMSIZE];
  logic [31:0] ref_mem [MEMSIZE];
  exp_t f_q[$];
  exp_t l_q[$];
  int owner_log[$];

  logic bh1, bh2, bh3;
  logic iss_rd, iss_wr;
  logic [31:0] iss_addr, iss_val;
  logic [2:0] iss_f3;
  int f_skip = 0;
  int l_skip = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] load_ext(logic [31:0] w, logic [2:0] f3);
    case (f3)
      3'd0:    return {{24{w[7]}}, w[7:0]};
      3'd1:    return {{16{w[15]}}, w[15:0]};
      3'd4:    return {24'd0, w[7:0]};
      3'd5:    return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(logic [31:0] old, logic [31:0] w, logic [2:0] f3);
    case (f3)
      3'd0:    return {old[31:8], w[7:0]};
      3'd1:    return {old[31:16], w[15:0]};
      default: return w;
    endcase
  endfunction

  // Reference model: outcome of one request judged from the access rules alone.
  function automatic exp_t ref_fetch(logic [31:0] a);
    exp_t e = '0;
    if (a < MEMSIZE) begin
      e.strobe = 1'b1;
      e.addr   = a;
      e.f3     = 3'd2;
      e.rdata  = ref_mem[a[5:0]];
    end
    return e;
  endfunction

  function automatic exp_t ref_ls(logic we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
    exp_t e = '0;
    logic ok;
    ok = (a < MEMSIZE) && (we ? (f3 inside {3'd0, 3'd1, 3'd2})
                               : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}));
    if (!ok) begin
      e.err = 1'b1;
    end else begin
      e.strobe = 1'b1;
      e.wr     = we;
      e.addr   = a;
      e.f3     = f3;
      e.val    = wd;
      if (we) ref_mem[a[5:0]] = store_merge(ref_mem[a[5:0]], wd, f3);
      else    e.rdata = load_ext(ref_mem[a[5:0]], f3);
    end
    return e;
  endfunction

  // Memory: samples strobes on the edge, returns read data the following cycle.
  always @(posedge clk) begin
    if (bus.mem_write && bus.mem_addr < MEMSIZE)
      tb_mem[bus.mem_addr[5:0]] <= store_merge(tb_mem[bus.mem_addr[5:0]], bus.mem_value, bus.mem_funct3);
    if (bus.mem_read && bus.mem_addr < MEMSIZE)
      bus.mem_data <= load_ext(tb_mem[bus.mem_addr[5:0]], bus.mem_funct3);
    else
      bus.mem_data <= $urandom;
  end

  function automatic void check_resp(string who, exp_t e, logic [31:0] rdata);
    chk({who, "_rdata"}, rdata, e.rdata);
    chk({who, "_read_strobe"}, 32'(iss_rd), 32'(e.strobe & ~e.wr));
    chk({who, "_write_strobe"}, 32'(iss_wr), 32'(e.strobe & e.wr));
    if (e.strobe) begin
      chk({who, "_mem_addr"}, iss_addr, e.addr);
      chk({who, "_mem_funct3"}, 32'(iss_f3), 32'(e.f3));
      if (e.wr) chk({who, "_mem_value"}, iss_val, e.val);
    end
    chk({who, "_ack_timing"}, 32'({bus.busy, bh1, bh2, bh3}), 32'(4'b0110));
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic issue_now;
    if (rst) begin
      bh1 = 1'b0; bh2 = 1'b0; bh3 = 1'b0;
    end else begin
      issue_now = bus.busy && !bh1;
      if (bus.mem_read || bus.mem_write) begin
        chk("strobe_in_issue", 32'(issue_now), 32'd1);
        chk("strobe_exclusive", 32'(bus.mem_read & bus.mem_write), 32'd0);
      end
      if (issue_now) begin
        iss_rd = bus.mem_read; iss_wr = bus.mem_write;
        iss_addr = bus.mem_addr; iss_f3 = bus.mem_funct3; iss_val = bus.mem_value;
      end
      if (bus.if_ack || bus.ls_ack)
        chk("single_ack", 32'(bus.if_ack & bus.ls_ack), 32'd0);
      if (bus.if_ack) begin
        chk("if_ack_has_request", 32'(f_q.size() != 0), 32'd1);
        if (f_q.size() != 0) begin
          e = f_q.pop_front();
          check_resp("fetch", e, bus.if_rdata);
        end
        owner_log.push_back(0);
        f_skip = 0;
        if (l_q.size() != 0) begin
          l_skip++;
          chk("ls_wait_bound", 32'(l_skip <= 1), 32'd1);
        end
      end
      if (bus.ls_ack) begin
        chk("ls_ack_has_request", 32'(l_q.size() != 0), 32'd1);
        if (l_q.size() != 0) begin
          e = l_q.pop_front();
          check_resp("ls", e, bus.ls_rdata);
          chk("ls_err", 32'(bus.ls_err), 32'(e.err));
        end
        owner_log.push_back(1);
        l_skip = 0;
        if (f_q.size() != 0) begin
          f_skip++;
          chk("fetch_wait_bound", 32'(f_skip <= 1), 32'd1);
        end
      end
      bh3 = bh2; bh2 = bh1; bh1 = bus.busy;
    end
  end

  task automatic fetch_txn(input logic [31:0] a, input bit keep, output int lat);
    f_q.push_back(ref_fetch(a));
    bus.if_addr = a;
    bus.if_req  = 1'b1;
    lat = 0;
    forever begin
      @(posedge clk); #1;
      lat++;
      if (bus.if_ack) break;
      if (lat > 40) begin
        chk("fetch_ack_timeout", 32'(lat), 32'd3);
        f_q.delete();
        break;
      end
    end
    if (!keep) bus.if_req = 1'b0;
  endtask

  task automatic ls_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit keep, output int lat);
    l_q.push_back(ref_ls(we, f3, a, wd));
    bus.ls_we = we; bus.ls_funct3 = f3; bus.ls_addr = a; bus.ls_wdata = wd;
    bus.ls_req = 1'b1;
    lat = 0;
    forever begin
      @(posedge clk); #1;
      lat++;
      if (bus.ls_ack) break;
      if (lat > 40) begin
        chk("ls_ack_timeout", 32'(lat), 32'd3);
        l_q.delete();
        break;
      end
    end
    if (!keep) bus.ls_req = 1'b0;
  endtask

  task automatic fetch_agent(input int n);
    int lat;
    bit keep;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(64, 300)) : 32'($urandom_range(0, 31));
      keep = (i < n - 1) && ($urandom_range(0, 2) == 0);
      fetch_txn(a, keep, lat);
      if (!keep) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic ls_agent(input int n);
    int lat;
    bit keep;
    logic we;
    logic [2:0] f3;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) a = 32'($urandom_range(64, 300));
      else a = we ? 32'($urandom_range(32, 63)) : 32'($urandom_range(0, 63));
      keep = (i < n - 1) && ($urandom_range(0, 2) == 0);
      ls_txn(we, f3, a, $urandom, keep, lat);
      if (!keep) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic int log_at(int i);
    return (i < owner_log.size()) ? owner_log[i] : -1;
  endfunction

  initial begin
    int lat;
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_funct3 = '0; bus.ls_addr = '0; bus.ls_wdata = '0;
    for (int i = 0; i < MEMSIZE; i++) begin
      tb_mem[i] = $urandom;
      ref_mem[i] = tb_mem[i];
    end
    tb_mem[5] = 32'hDEADBEEF; ref_mem[5] = 32'hDEADBEEF;
    tb_mem[3] = 32'h00000080; ref_mem[3] = 32'h00000080;

    @(posedge clk); #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_if_ack", 32'(bus.if_ack), 32'd0);
    chk("rst_ls_ack", 32'(bus.ls_ack), 32'd0);
    chk("rst_ls_err", 32'(bus.ls_err), 32'd0);
    chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
    chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_if_rdata", bus.if_rdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Tie straight after reset: L, F, L, F.
    owner_log.delete();
    fork
      begin ls_txn(1'b0, 3'd0, 32'd3, 32'd0, 1'b1, lat); ls_txn(1'b0, 3'd0, 32'd3, 32'd0, 1'b0, lat); end
      begin fetch_txn(32'd10, 1'b1, lat); fetch_txn(32'd11, 1'b0, lat); end
    join
    settle();
    chk("tie_order_first", 32'(log_at(0)), 32'd1);
    chk("tie_order_second", 32'(log_at(1)), 32'd0);
    chk("tie_order_third", 32'(log_at(2)), 32'd1);

    fetch_txn(32'd5, 1'b0, lat);
    chk("fetch_alone_latency", 32'(lat), 32'd3);
    settle();

    ls_txn(1'b1, 3'd1, 32'd7, 32'h1234ABCD, 1'b0, lat);
    ls_txn(1'b0, 3'd2, 32'd7, 32'd0, 1'b0, lat);
    ls_txn(1'b1, 3'd4, 32'd8, 32'hFFFF0000, 1'b0, lat);
    ls_txn(1'b0, 3'd2, 32'd64, 32'd0, 1'b0, lat);
    ls_txn(1'b0, 3'd6, 32'd9, 32'd0, 1'b0, lat);
    fetch_txn(32'd100, 1'b0, lat);
    settle();

    // Abandon an LSU load in ISSUE; its ack must never appear.
    bus.ls_we = 1'b0; bus.ls_funct3 = 3'd2; bus.ls_addr = 32'd40; bus.ls_req = 1'b1;
    @(posedge clk); #1;
    chk("pre_reset_issue_read", 32'(bus.mem_read), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort_mem_read", 32'(bus.mem_read), 32'd0);
    chk("abort_mem_write", 32'(bus.mem_write), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_acks", 32'({bus.if_ack, bus.ls_ack}), 32'd0);
    bus.ls_req = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_idle_busy", 32'(bus.busy), 32'd0);

    owner_log.delete();
    fork
      ls_txn(1'b0, 3'd4, 32'd3, 32'd0, 1'b0, lat);
      fetch_txn(32'd12, 1'b0, lat);
    join
    settle();
    chk("post_reset_tie_first", 32'(log_at(0)), 32'd1);

    // Fetch streams back-to-back while LSU waits.
    owner_log.delete();
    fork
      begin fetch_txn(32'd1, 1'b1, lat); fetch_txn(32'd2, 1'b1, lat); fetch_txn(32'd4, 1'b0, lat); end
      begin @(posedge clk); #1; ls_txn(1'b0, 3'd2, 32'd20, 32'd0, 1'b0, lat); end
    join
    settle();
    chk("contention_first", 32'(log_at(0)), 32'd0);
    chk("contention_second", 32'(log_at(1)), 32'd1);

    fork
      fetch_agent(60);
      ls_agent(60);
    join
    settle();
    chk("fetch_queue_drained", 32'(f_q.size()), 32'd0);
    chk("ls_queue_drained", 32'(l_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEMSIZE, default 64, meaning number of 32-bit words in the attached memory; legal addresses are 0..MEMSIZE-1.
REQ-002 SHALL have ports (name direction width meaning):
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch read request.
- if_addr  in  32  fetch word address.
- if_ack  out  1  fetch completion pulse.
- if_rdata  out  32  fetch data, valid with if_ack.
- ls_req  in  1  load/store request.
- ls_we  in  1  1 = store, 0 = load.
- ls_funct3  in  3  access size/sign code.
- ls_addr  in  32  load/store word address.
- ls_wdata  in  32  store data.
- ls_ack  out  1  load/store completion pulse.
- ls_rdata  out  32  load data, valid with ls_ack.
- ls_err  out  1  load/store rejected, valid with ls_ack.
- mem_addr  out  32  memory address.
- mem_value  out  32  memory write data.
- mem_funct3  out  3  memory size code.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_data  in  32  memory read data, valid the cycle after the sampling edge.
- busy  out  1  arbiter not in IDLE.

Function
REQ-003 SHALL implement FSM states IDLE, ISSUE, RESP; all outputs registered.
REQ-004 IDLE: if any req is high, latch the winner's addr/data/funct3/we and go to ISSUE; otherwise stay in IDLE.
REQ-005 Winner when only one requester is high: that requester.
REQ-006 Winner when both are high: the requester not granted last (round-robin); last-grant pointer resets to "fetch", so LSU wins the first tie.
REQ-007 ISSUE: drive latched access onto mem_*, for exactly one cycle, then go to RESP.
REQ-008 Fetch access SHALL be mem_read=1, mem_funct3=3'd2.
REQ-009 LSU access SHALL use mem_funct3=ls_funct3 and mem_read=!ls_we, mem_write=ls_we.
REQ-010 mem_read and mem_write SHALL never be high together, and SHALL be 0 outside ISSUE.
REQ-011 RESP: pulse the owner's ack for one cycle, with rdata=mem_data for reads and rdata=0 for stores, then go to IDLE.
REQ-012 Latency SHALL be: req sampled at edge E, ack high in cycle following edge E+2; at most one transaction per 3 cycles.
REQ-013 Requester SHALL hold req and operands stable until ack; a req still high in IDLE after ack is a new request.
REQ-014 Non-owner req SHALL be ignored (held pending) while busy; no ack to non-owner.
REQ-015 LSU illegal cases SHALL be rejected:
- load with funct3 in {3,6,7};
- store with funct3 not in {0,1,2};
- ls_addr >= MEMSIZE.
REQ-016 On rejection: pass through ISSUE with mem_read=mem_write=0, then in RESP assert ls_ack=1, ls_err=1, ls_rdata=0.
REQ-017 Fetch with if_addr >= MEMSIZE SHALL be issued with mem_read=0 and ack with if_rdata=0; no error port.
REQ-018 Pointer SHALL update only on grant, including rejected grants.
REQ-019 busy SHALL be 1 in ISSUE and RESP.

Reset
REQ-020 rst high SHALL immediately force IDLE, pointer=fetch, and all outputs to 0 (mem_* included), without waiting for clk.
REQ-021 Reset mid-transaction SHALL abandon it: no ack, no memory strobe after reset assertion; first post-reset grant follows REQ-004..REQ-006.

Verification
REQ-022 Bench SHALL cover these scenarios:
- Fetch alone: if_req, if_addr=5, mem[5]=0xDEADBEEF -> mem_read pulse with mem_addr=5, mem_funct3=2; if_ack 3 cycles after request edge with if_rdata=0xDEADBEEF.
- Tie after reset: if_req=ls_req=1, ls load addr=3, funct3=0, mem[3]=0x80 -> LSU first, ls_rdata=0xFFFFFF80; then fetch granted; then with both still high, LSU again (alternation).
- Store: ls_we=1, funct3=1, addr=7, wdata=0x1234ABCD -> single mem_write cycle with mem_value=0x1234ABCD, mem_funct3=1; ls_ack with ls_rdata=0, ls_err=0.
- Illegal: store funct3=4 -> no strobe, ls_ack=1, ls_err=1; load addr=64 (MEMSIZE=64) -> same.
- Reset in ISSUE: assert rst mid-cycle -> mem_read/mem_write/acks drop to 0 before next edge; no ack for aborted request; busy=0.
- Contention hold: ls_req held through 3 back-to-back fetches with if_req continuously high -> LSU granted no later than the second arbitration.
